seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Memory-mapped 8-digit 7-segment display scan controller attached to the data bus as a peripheral slave. It holds display contents and scan configuration in registers, time-multiplexes the eight common-anode digits with a programmable on-time and inter-digit blanking gap, and raises a frame-done interrupt. It replaces the free-running, fixed-rate display driver at SoC top and is sequenced entirely by software through the bus.

## Interface
- No parameters; register map and widths are fixed.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- sel_i  in  1  peripheral select from the dbus address decoder.
- we_i  in  1  1 = write, 0 = read; sampled when sel_i=1.
- addr_i  in  5  byte address; only [4:2] is decoded, [1:0] ignored.
- wdata_i  in  32  write data; full-word writes only.
- rdata_o  out  32  read data; valid when ack_o=1, otherwise 0.
- ack_o  out  1  one-cycle acknowledge for every access.
- seg_o  out  8  cathode drive, active-low, bit7=DP, bits6..0=a..g.
- an_o  out  8  anode select, active-low, bit k = digit k.
- irq_o  out  1  level interrupt = STATUS.FD & CTRL.IE.

## Operation
- Registers (offset: field, reset value):
  - 0x00 CTRL: [0] EN=0, [1] RAW=0, [2] IE=0, [15:8] DP mask=0x00, [23:16] digit enable=0xFF.
  - 0x04 HEX: 0. Nibble k drives digit k.
  - 0x08 RAW_LO: 0. Byte k drives digit k, for k=0..3.
  - 0x0C RAW_HI: 0. Byte k drives digit 4+k.
  - 0x10 PRESCALE[19:0]: 199999. Digit on-time = PRESCALE+1 cycles.
  - 0x14 BLANK[7:0]: 0. Gap cycles inserted after each digit.
  - 0x18 STATUS: [2:0] current digit (RO); [3] FD frame-done (sticky, write 1 to clear).
  - Unused offsets: read 0, writes ignored. Unused bits: read 0.
- Hex decode (active-high segment pattern before inversion): 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B A:77 b:1F C:4E d:3D E:4F F:47.
- Segment pattern for digit k:
  - RAW=1: the raw byte for digit k.
  - RAW=0: {DP mask[k], decode[6:0]}.
  - Digit enable[k]=0: pattern is 0x00 and the anode stays off for that slot. Slot timing is unchanged.
- Shadowing: HEX, RAW_LO, RAW_HI, CTRL[1] and CTRL[23:8] are copied into shadow registers on every entry to digit 0. The scan always uses the shadow copies, so a frame never tears. PRESCALE and BLANK are also sampled at digit 0 entry.
- FSM states: IDLE, DRIVE, GAP.
  - IDLE: an_o=0xFF, seg_o=0xFF. Go to DRIVE with digit=0 (shadow load) when EN=1.
  - DRIVE: on-time counter counts 0..PRESCALE. At terminal count: go to GAP if BLANK≠0, else directly to DRIVE of digit+1.
  - GAP: an_o=0xFF, seg_o=0xFF for BLANK cycles, then DRIVE of digit+1.
  - Digit wraps 7→0. On that wrap FD is set and shadows reload.
- EN cleared at any time: IDLE on the next cycle, digit reset to 0, counters cleared. FD is preserved.
- Simultaneous FD set and software W1C of FD in the same cycle: set wins.

## Timing
- Bus access:
  - Request sampled at cycle N with sel_i=1. ack_o=1 at N+1 for exactly one cycle.
  - Reads: rdata_o at N+1 reflects register state as of cycle N.
  - Writes: register updated at the N→N+1 edge.
  - Back-to-back accesses are allowed every cycle.
- Scan outputs:
  - seg_o and an_o are registered. They reflect the FSM state/digit with one cycle of latency.
  - EN write at cycle N: state becomes DRIVE digit 0 at N+1; first anode low (an_o=0xFE) at N+2.
- Frame period = 8×(PRESCALE+1+BLANK) cycles.
- FD timing: FD sets in the same cycle the FSM enters digit 0 after digit 7. irq_o follows combinationally from the FD and IE registers.
- Reset values:
  - rdata_o=0, ack_o=0, seg_o=0xFF, an_o=0xFF, irq_o=0.
  - FSM in IDLE, digit=0, all counters 0.
  - Registers take the reset values listed above.
- Reset asserted mid-scan: all of the above values are restored at the next edge.

## Test plan
- **Reset and enable:** write CTRL=0x00FF0001, PRESCALE=3, BLANK=0, HEX=0x76543210.
  - an_o cycles FE,FD,FB,…,7F, each held 4 cycles.
  - seg_o = ~decode: 0x81 for "0", then 0xCF for "1".
  - Period is 32 cycles.
- **Gap insertion:** PRESCALE=1, BLANK=2.
  - Pattern per digit: 2 cycles anode active, then 2 cycles an_o=0xFF, seg_o=0xFF.
  - FD sets every 32 cycles.
- **Shadowing:** write HEX=0xFFFFFFFF while digit 3 is active.
  - Digits 4–7 in the current frame still show the old value.
  - The next frame shows "F" on all digits (seg_o=0xB8).
- **RAW mode with masks:**
  - CTRL=0x00F0FF03, RAW_LO=0x80808080: digits 0–3 blanked (an_o never asserts their bits).
  - CTRL=0x00FF0003, RAW_LO=0x80808080: digits 0–3 show seg_o=0x7F (DP only).
- **Interrupt and W1C race:**
  - IE=1: irq_o rises at frame wrap.
  - Write STATUS=0x8: irq_o clears.
  - A W1C write landing on the exact wrap cycle leaves FD=1.
- **Disable mid-scan:** clear EN while digit 5 is driven.
  - Next cycle state is IDLE; cycle after, an_o=0xFF, seg_o=0xFF.
  - Re-enable restarts at digit 0.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: bus-mapped 8-digit common-anode 7-segment scan controller.
// Software programs display data and scan timing through registers. A three-process
// FSM walks the digits using shadow copies latched at each frame start, so a frame
// never shows a mix of old and new contents.
module seg7_scan_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel_i,
  input  logic        we_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic [7:0]  seg_o,
  output logic [7:0]  an_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Active-high a..g pattern for one hex nibble
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0: hex_decode = 7'h7E;
      4'h1: hex_decode = 7'h30;
      4'h2: hex_decode = 7'h6D;
      4'h3: hex_decode = 7'h79;
      4'h4: hex_decode = 7'h33;
      4'h5: hex_decode = 7'h5B;
      4'h6: hex_decode = 7'h5F;
      4'h7: hex_decode = 7'h70;
      4'h8: hex_decode = 7'h7F;
      4'h9: hex_decode = 7'h7B;
      4'hA: hex_decode = 7'h77;
      4'hB: hex_decode = 7'h1F;
      4'hC: hex_decode = 7'h4E;
      4'hD: hex_decode = 7'h3D;
      4'hE: hex_decode = 7'h4F;
      4'hF: hex_decode = 7'h47;
      default: hex_decode = 7'h00;
    endcase
  endfunction

  // Software-visible registers
  logic        en_r, raw_r, ie_r, fd_r;
  logic [7:0]  dp_r, den_r, blank_r;
  logic [31:0] hex_r, rlo_r, rhi_r;
  logic [19:0] pre_r;

  // Register values after the write pending this cycle (if any)
  logic        en_nxt_s, raw_nxt_s, ie_nxt_s, w1c_s;
  logic [7:0]  dp_nxt_s, den_nxt_s, blank_nxt_s;
  logic [31:0] hex_nxt_s, rlo_nxt_s, rhi_nxt_s;
  logic [19:0] pre_nxt_s;
  logic [2:0]  wr_sel_s;

  // Frame shadows
  logic        sh_raw_r;
  logic [7:0]  sh_dp_r, sh_den_r, sh_blank_r;
  logic [31:0] sh_hex_r, sh_rlo_r, sh_rhi_r;
  logic [19:0] sh_pre_r;

  // Scan FSM
  state_t      state_r, state_nxt_s;
  logic [2:0]  digit_r, digit_nxt_s;
  logic [19:0] cnt_r, cnt_nxt_s;
  logic        load_s, wrap_s;

  // Outputs and bus
  logic [7:0]  seg_s, an_s, seg_r, an_r;
  logic [3:0]  nibble_s;
  logic [7:0]  raw_byte_s;
  logic [31:0] rd_s, rdata_r;
  logic        ack_r;
  logic        unused_addr_s;

  // Offset 7 is unmapped, so it doubles as the "no write" selector
  assign wr_sel_s      = (sel_i && we_i) ? addr_i[4:2] : 3'd7;
  assign unused_addr_s = ^addr_i[1:0];

  // Overlay the current bus write onto the register values
  always_comb begin
    en_nxt_s    = en_r;
    raw_nxt_s   = raw_r;
    ie_nxt_s    = ie_r;
    dp_nxt_s    = dp_r;
    den_nxt_s   = den_r;
    hex_nxt_s   = hex_r;
    rlo_nxt_s   = rlo_r;
    rhi_nxt_s   = rhi_r;
    pre_nxt_s   = pre_r;
    blank_nxt_s = blank_r;
    w1c_s       = 1'b0;
    case (wr_sel_s)
      3'd0: begin
        en_nxt_s  = wdata_i[0];
        raw_nxt_s = wdata_i[1];
        ie_nxt_s  = wdata_i[2];
        dp_nxt_s  = wdata_i[15:8];
        den_nxt_s = wdata_i[23:16];
      end
      3'd1: hex_nxt_s   = wdata_i;
      3'd2: rlo_nxt_s   = wdata_i;
      3'd3: rhi_nxt_s   = wdata_i;
      3'd4: pre_nxt_s   = wdata_i[19:0];
      3'd5: blank_nxt_s = wdata_i[7:0];
      3'd6: w1c_s       = wdata_i[3];
      default: w1c_s    = 1'b0;
    endcase
  end

  // Register file update; a frame-done set beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      en_r    <= 1'b0;
      raw_r   <= 1'b0;
      ie_r    <= 1'b0;
      dp_r    <= 8'h00;
      den_r   <= 8'hFF;
      hex_r   <= 32'h0000_0000;
      rlo_r   <= 32'h0000_0000;
      rhi_r   <= 32'h0000_0000;
      pre_r   <= 20'd199999;
      blank_r <= 8'h00;
      fd_r    <= 1'b0;
    end else begin
      en_r    <= en_nxt_s;
      raw_r   <= raw_nxt_s;
      ie_r    <= ie_nxt_s;
      dp_r    <= dp_nxt_s;
      den_r   <= den_nxt_s;
      hex_r   <= hex_nxt_s;
      rlo_r   <= rlo_nxt_s;
      rhi_r   <= rhi_nxt_s;
      pre_r   <= pre_nxt_s;
      blank_r <= blank_nxt_s;
      fd_r    <= wrap_s ? 1'b1 : (w1c_s ? 1'b0 : fd_r);
    end
  end

  // Latch display data and timing whenever digit 0 is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_raw_r   <= 1'b0;
      sh_dp_r    <= 8'h00;
      sh_den_r   <= 8'hFF;
      sh_hex_r   <= 32'h0000_0000;
      sh_rlo_r   <= 32'h0000_0000;
      sh_rhi_r   <= 32'h0000_0000;
      sh_pre_r   <= 20'd0;
      sh_blank_r <= 8'h00;
    end else if (load_s) begin
      sh_raw_r   <= raw_nxt_s;
      sh_dp_r    <= dp_nxt_s;
      sh_den_r   <= den_nxt_s;
      sh_hex_r   <= hex_nxt_s;
      sh_rlo_r   <= rlo_nxt_s;
      sh_rhi_r   <= rhi_nxt_s;
      sh_pre_r   <= pre_nxt_s;
      sh_blank_r <= blank_nxt_s;
    end else begin
      sh_raw_r   <= sh_raw_r;
    end
  end

  // FSM state, digit and on-time/gap counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      digit_r <= 3'd0;
      cnt_r   <= 20'd0;
    end else begin
      state_r <= state_nxt_s;
      digit_r <= digit_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic: EN low forces IDLE; wrap 7->0 reloads shadows and flags frame-done
  always_comb begin
    state_nxt_s = state_r;
    digit_nxt_s = digit_r;
    cnt_nxt_s   = cnt_r;
    load_s      = 1'b0;
    wrap_s      = 1'b0;
    if (!en_nxt_s) begin
      state_nxt_s = ST_IDLE;
      digit_nxt_s = 3'd0;
      cnt_nxt_s   = 20'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_DRIVE;
          digit_nxt_s = 3'd0;
          cnt_nxt_s   = 20'd0;
          load_s      = 1'b1;
        end
        ST_DRIVE: begin
          if (cnt_r == sh_pre_r) begin
            cnt_nxt_s = 20'd0;
            if (sh_blank_r != 8'h00) begin
              state_nxt_s = ST_GAP;
            end else begin
              state_nxt_s = ST_DRIVE;
              digit_nxt_s = digit_r + 3'd1;
              wrap_s      = (digit_r == 3'd7);
              load_s      = (digit_r == 3'd7);
            end
          end else begin
            cnt_nxt_s = cnt_r + 20'd1;
          end
        end
        ST_GAP: begin
          if ((cnt_r + 20'd1) == {12'd0, sh_blank_r}) begin
            cnt_nxt_s   = 20'd0;
            state_nxt_s = ST_DRIVE;
            digit_nxt_s = digit_r + 3'd1;
            wrap_s      = (digit_r == 3'd7);
            load_s      = (digit_r == 3'd7);
          end else begin
            cnt_nxt_s = cnt_r + 20'd1;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          digit_nxt_s = 3'd0;
          cnt_nxt_s   = 20'd0;
        end
      endcase
    end
  end

  assign nibble_s   = sh_hex_r[{digit_r, 2'b00} +: 4];
  assign raw_byte_s = digit_r[2] ? sh_rhi_r[{digit_r[1:0], 3'b000} +: 8]
                                 : sh_rlo_r[{digit_r[1:0], 3'b000} +: 8];

  // Output decode: only an enabled digit in DRIVE lights anything
  always_comb begin
    seg_s = 8'hFF;
    an_s  = 8'hFF;
    if ((state_r == ST_DRIVE) && sh_den_r[digit_r]) begin
      an_s  = ~(8'd1 << digit_r);
      seg_s = sh_raw_r ? ~raw_byte_s : ~{sh_dp_r[digit_r], hex_decode(nibble_s)};
    end else begin
      seg_s = 8'hFF;
      an_s  = 8'hFF;
    end
  end

  // Register the drive outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r <= 8'hFF;
      an_r  <= 8'hFF;
    end else begin
      seg_r <= seg_s;
      an_r  <= an_s;
    end
  end

  // Read mux over current register state
  always_comb begin
    rd_s = 32'h0000_0000;
    case (addr_i[4:2])
      3'd0: rd_s = {8'h00, den_r, dp_r, 5'b00000, ie_r, raw_r, en_r};
      3'd1: rd_s = hex_r;
      3'd2: rd_s = rlo_r;
      3'd3: rd_s = rhi_r;
      3'd4: rd_s = {12'h000, pre_r};
      3'd5: rd_s = {24'h00_0000, blank_r};
      3'd6: rd_s = {28'h000_0000, fd_r, digit_r};
      default: rd_s = 32'h0000_0000;
    endcase
  end

  // One-cycle acknowledge; read data is zero except on a read ack
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      ack_r   <= sel_i;
      rdata_r <= (sel_i && !we_i) ? rd_s : 32'h0000_0000;
    end
  end

  assign rdata_o = rdata_r;
  assign ack_o   = ack_r;
  assign seg_o   = seg_r;
  assign an_o    = an_r;
  assign irq_o   = fd_r & ie_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: a frame-time model (elapsed cycles within a frame,
// digit = t / slot length) predicts every bus and display output.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel_i, we_i;
  logic [4:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o, irq_o;
  logic [7:0]  seg_o, an_o;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_scan_ctrl dut (
    .clk(clk), .rst(rst), .sel_i(sel_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .ack_o(ack_o), .seg_o(seg_o),
    .an_o(an_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LUT [0:15] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Model registers, frame snapshot and frame clock
  logic        m_en, m_raw, m_ie, m_fd;
  logic [7:0]  m_dp, m_den, m_blank;
  logic [31:0] m_hex, m_rlo, m_rhi;
  logic [19:0] m_pre;
  logic        s_raw;
  logic [7:0]  s_dp, s_den, s_blank;
  logic [31:0] s_hex, s_rlo, s_rhi;
  logic [19:0] s_pre;
  bit          m_run;
  int          m_t;
  logic        exp_ack, exp_irq;
  logic [31:0] exp_rdata;
  logic [7:0]  exp_an, exp_seg;

  function automatic int per();
    return int'(s_pre) + 1 + int'(s_blank);
  endfunction

  function automatic int m_slot();
    return m_run ? (m_t / per()) : 0;
  endfunction

  function automatic bit wrap_next();
    return m_run && m_en && ((m_t + 1) == 8 * per());
  endfunction

  task automatic snapshot();
    s_raw = m_raw; s_dp = m_dp; s_den = m_den; s_hex = m_hex;
    s_rlo = m_rlo; s_rhi = m_rhi; s_pre = m_pre; s_blank = m_blank;
  endtask

  // Advance the model across one clock edge using the inputs currently driven
  task automatic model_edge();
    int p, slot, off;
    logic [31:0] rd;
    logic [7:0] pat;
    logic w1c, wrap;
    if (rst) begin
      m_en = 1'b0; m_raw = 1'b0; m_ie = 1'b0; m_fd = 1'b0;
      m_dp = 8'h00; m_den = 8'hFF; m_blank = 8'h00;
      m_hex = 32'h0; m_rlo = 32'h0; m_rhi = 32'h0; m_pre = 20'd199999;
      s_pre = 20'd0; s_blank = 8'h00;
      m_run = 1'b0; m_t = 0;
      exp_ack = 1'b0; exp_rdata = 32'h0; exp_an = 8'hFF; exp_seg = 8'hFF; exp_irq = 1'b0;
    end else begin
      p    = per();
      slot = m_slot();
      off  = m_run ? (m_t % p) : 0;
      case (addr_i[4:2])
        3'd0: rd = {8'h00, m_den, m_dp, 5'h00, m_ie, m_raw, m_en};
        3'd1: rd = m_hex;
        3'd2: rd = m_rlo;
        3'd3: rd = m_rhi;
        3'd4: rd = {12'h000, m_pre};
        3'd5: rd = {24'h000000, m_blank};
        3'd6: rd = {28'h0000000, m_fd, 3'(slot)};
        default: rd = 32'h0;
      endcase
      exp_ack   = sel_i;
      exp_rdata = (sel_i && !we_i) ? rd : 32'h0;
      exp_an    = 8'hFF;
      exp_seg   = 8'hFF;
      if (m_run && (off <= int'(s_pre)) && s_den[slot]) begin
        if (s_raw) pat = (slot < 4) ? s_rlo[8*slot +: 8] : s_rhi[8*(slot-4) +: 8];
        else pat = {s_dp[slot], LUT[s_hex[4*slot +: 4]]};
        exp_an  = ~(8'd1 << slot);
        exp_seg = ~pat;
      end
      w1c = 1'b0;
      if (sel_i && we_i) begin
        case (addr_i[4:2])
          3'd0: begin
            m_en = wdata_i[0]; m_raw = wdata_i[1]; m_ie = wdata_i[2];
            m_dp = wdata_i[15:8]; m_den = wdata_i[23:16];
          end
          3'd1: m_hex = wdata_i;
          3'd2: m_rlo = wdata_i;
          3'd3: m_rhi = wdata_i;
          3'd4: m_pre = wdata_i[19:0];
          3'd5: m_blank = wdata_i[7:0];
          3'd6: w1c = wdata_i[3];
          default: w1c = 1'b0;
        endcase
      end
      wrap = 1'b0;
      if (!m_en) begin
        m_run = 1'b0; m_t = 0;
      end else if (!m_run) begin
        m_run = 1'b1; m_t = 0; snapshot();
      end else if ((m_t + 1) == 8 * p) begin
        m_t = 0; wrap = 1'b1; snapshot();
      end else begin
        m_t = m_t + 1;
      end
      m_fd    = wrap ? 1'b1 : (w1c ? 1'b0 : m_fd);
      exp_irq = m_fd & m_ie;
    end
  endtask

  task automatic tick(input logic s, input logic w, input logic [4:0] a, input logic [31:0] d);
    sel_i = s; we_i = w; addr_i = a; wdata_i = d;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 5'h00, 32'h0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    tick(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [4:0] a);
    tick(1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    n_checks++;
    if ({ack_o, rdata_o, an_o, seg_o, irq_o} !== {1'b0, 32'h0, 8'hFF, 8'hFF, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b rdata=%h an=%h seg=%h irq=%b expected 0/0/FF/FF/0",
               ack_o, rdata_o, an_o, seg_o, irq_o);
    end
    rd(5'h00);
    n_checks++;
    if (rdata_o !== 32'h00FF0000 || ack_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %h ack=%b expected 00ff0000 ack=1", rdata_o, ack_o);
    end
    idle();
    n_checks++;
    if (ack_o !== 1'b0 || rdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL ack_single: ack=%b rdata=%h expected 0/0", ack_o, rdata_o);
    end
    rd(5'h10);
    n_checks++;
    if (rdata_o !== 32'd199999) begin
      n_fail++;
      $display("FAIL reset_prescale: got %0d expected 199999", rdata_o);
    end
    for (int a = 0; a < 8; a++) begin
      rd(5'(a * 4 + 1));
      n_checks++;
      if (rdata_o !== exp_rdata) begin
        n_fail++;
        $display("FAIL reset_regs[%0d]: got %h expected %h", a, rdata_o, exp_rdata);
      end
    end
  endtask

  task automatic test_enable();
    wr(5'h10, 32'd3);
    wr(5'h14, 32'd0);
    wr(5'h04, 32'h76543210);
    wr(5'h00, 32'h00FF0001);
    n_checks++;
    if (an_o !== 8'hFF) begin
      n_fail++;
      $display("FAIL enable_latency: an=%h expected ff", an_o);
    end
    idle();
    n_checks++;
    if (an_o !== 8'hFE || seg_o !== 8'h81) begin
      n_fail++;
      $display("FAIL enable_digit0: an/seg=%h/%h expected fe/81", an_o, seg_o);
    end
    repeat (4) idle();
    n_checks++;
    if (an_o !== 8'hFD || seg_o !== 8'hCF) begin
      n_fail++;
      $display("FAIL enable_digit1: an/seg=%h/%h expected fd/cf", an_o, seg_o);
    end
    for (int i = 0; i < 70; i++) begin
      idle();
      n_checks++;
      if ({an_o, seg_o} !== {exp_an, exp_seg}) begin
        n_fail++;
        $display("FAIL enable_scan: cyc %0d an/seg=%h/%h expected %h/%h", i, an_o, seg_o, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_gap();
    wr(5'h10, 32'd1);
    wr(5'h14, 32'd2);
    for (int i = 0; i < 110; i++) begin
      if (i % 9 == 0) rd(5'h18);
      else idle();
      n_checks++;
      if ({an_o, seg_o, rdata_o} !== {exp_an, exp_seg, exp_rdata}) begin
        n_fail++;
        $display("FAIL gap_scan: cyc %0d an/seg/rdata=%h/%h/%h expected %h/%h/%h",
                 i, an_o, seg_o, rdata_o, exp_an, exp_seg, exp_rdata);
      end
    end
  endtask

  task automatic test_shadow();
    wr(5'h10, 32'd3);
    wr(5'h14, 32'd0);
    wr(5'h04, 32'h0);
    repeat (45) idle();
    for (int i = 0; i < 64 && m_slot() != 3; i++) idle();
    wr(5'h04, 32'hFFFFFFFF);
    for (int i = 0; i < 40 && an_o !== 8'h7F; i++) idle();
    n_checks++;
    if (an_o !== 8'h7F || seg_o !== 8'h81) begin
      n_fail++;
      $display("FAIL shadow_old_frame: an/seg=%h/%h expected 7f/81", an_o, seg_o);
    end
    for (int i = 0; i < 40 && an_o !== 8'hFE; i++) idle();
    n_checks++;
    if (an_o !== 8'hFE || seg_o !== 8'hB8) begin
      n_fail++;
      $display("FAIL shadow_new_frame: an/seg=%h/%h expected fe/b8", an_o, seg_o);
    end
    for (int i = 0; i < 40; i++) begin
      idle();
      n_checks++;
      if ({an_o, seg_o} !== {exp_an, exp_seg}) begin
        n_fail++;
        $display("FAIL shadow_scan: an/seg=%h/%h expected %h/%h", an_o, seg_o, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_raw();
    wr(5'h08, 32'h80808080);
    wr(5'h0C, $urandom);
    wr(5'h00, 32'h00F0FF03);
    for (int i = 0; i < 64 && !(m_run && m_t == 0); i++) idle();
    for (int i = 0; i < 70; i++) begin
      idle();
      n_checks++;
      if (an_o[3:0] !== 4'hF || {an_o, seg_o} !== {exp_an, exp_seg}) begin
        n_fail++;
        $display("FAIL raw_masked: an/seg=%h/%h expected %h/%h", an_o, seg_o, exp_an, exp_seg);
      end
    end
    wr(5'h00, 32'h00FF0003);
    for (int i = 0; i < 64 && !(m_run && m_t == 0); i++) idle();
    for (int i = 0; i < 70; i++) begin
      idle();
      n_checks++;
      if ((an_o[3:0] !== 4'hF && seg_o !== 8'h7F) || {an_o, seg_o} !== {exp_an, exp_seg}) begin
        n_fail++;
        $display("FAIL raw_dp: an/seg=%h/%h expected %h/%h", an_o, seg_o, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_irq();
    wr(5'h00, 32'h00FF0005);
    wr(5'h18, 32'h8);
    for (int i = 0; i < 80 && !exp_irq; i++) begin
      idle();
      n_checks++;
      if (irq_o !== exp_irq) begin
        n_fail++;
        $display("FAIL irq_track: irq=%b expected %b", irq_o, exp_irq);
      end
    end
    n_checks++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_rise: irq=%b expected 1", irq_o);
    end
    wr(5'h18, 32'h8);
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_w1c: irq=%b expected 0", irq_o);
    end
    for (int i = 0; i < 80 && !wrap_next(); i++) idle();
    wr(5'h18, 32'h8);
    n_checks++;
    if (irq_o !== 1'b1 || exp_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_race: irq=%b expected 1", irq_o);
    end
  endtask

  task automatic test_disable();
    wr(5'h00, 32'h00FF0001);
    for (int i = 0; i < 80 && m_slot() != 5; i++) idle();
    wr(5'h00, 32'h00FF0000);
    n_checks++;
    if (an_o !== 8'hDF) begin
      n_fail++;
      $display("FAIL disable_last_digit: an=%h expected df", an_o);
    end
    rd(5'h18);
    n_checks++;
    if (an_o !== 8'hFF || seg_o !== 8'hFF || rdata_o[2:0] !== 3'd0 || rdata_o !== exp_rdata) begin
      n_fail++;
      $display("FAIL disable_idle: an/seg/status=%h/%h/%h expected ff/ff/%h", an_o, seg_o, rdata_o, exp_rdata);
    end
    wr(5'h00, 32'h00FF0001);
    idle();
    n_checks++;
    if (an_o !== 8'hFE) begin
      n_fail++;
      $display("FAIL reenable_digit0: an=%h expected fe", an_o);
    end
  endtask

  task automatic test_random();
    int op, idx;
    logic [31:0] d;
    for (int i = 0; i < 900; i++) begin
      op  = $urandom_range(0, 9);
      idx = $urandom_range(0, 7);
      d   = $urandom;
      if (idx == 4) d = 32'($urandom_range(0, 4));
      if (idx == 5) d = 32'($urandom_range(0, 3));
      if (idx == 0) d[0] = ($urandom_range(0, 5) != 0);
      if (op < 2) wr(5'(idx * 4 + $urandom_range(0, 3)), d);
      else if (op < 4) rd(5'(idx * 4 + $urandom_range(0, 3)));
      else idle();
      n_checks++;
      if ({ack_o, rdata_o, an_o, seg_o, irq_o} !== {exp_ack, exp_rdata, exp_an, exp_seg, exp_irq}) begin
        n_fail++;
        $display("FAIL random: cyc %0d ack/rdata/an/seg/irq=%b/%h/%h/%h/%b expected %b/%h/%h/%h/%b",
                 i, ack_o, rdata_o, an_o, seg_o, irq_o, exp_ack, exp_rdata, exp_an, exp_seg, exp_irq);
      end
    end
  endtask

  task automatic test_reset_midscan();
    wr(5'h10, 32'd2);
    wr(5'h00, 32'h00FF0005);
    repeat (30) idle();
    rst = 1'b1;
    tick(1'b1, 1'b0, 5'h00, 32'h0);
    rst = 1'b0;
    n_checks++;
    if ({ack_o, rdata_o, an_o, seg_o, irq_o} !== {1'b0, 32'h0, 8'hFF, 8'hFF, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_midscan: ack=%b rdata=%h an=%h seg=%h irq=%b expected 0/0/FF/FF/0",
               ack_o, rdata_o, an_o, seg_o, irq_o);
    end
    rd(5'h00);
    n_checks++;
    if (rdata_o !== 32'h00FF0000) begin
      n_fail++;
      $display("FAIL reset_midscan_ctrl: got %h expected 00ff0000", rdata_o);
    end
    idle();
    n_checks++;
    if (an_o !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_midscan_idle: an=%h expected ff", an_o);
    end
  endtask

  initial begin
    rst = 1'b1; sel_i = 1'b0; we_i = 1'b0; addr_i = 5'h00; wdata_i = 32'h0;
    test_reset();
    test_enable();
    test_gap();
    test_shadow();
    test_raw();
    test_irq();
    test_disable();
    test_random();
    test_reset_midscan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
